// File: rtl/bitstream_collector_if.sv
// Packed entropy-encoder output bus into the bitstream collector, plus its byte-stream side.
// master drives the encoder bytes and out_ready; slave is the collector.
interface bitstream_collector_if #(
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned PTR_WIDTH  = 4,
  parameter int unsigned CNT_WIDTH  = 32
);
  logic [BYTE_WIDTH-1:0] in_bit_1;
  logic [BYTE_WIDTH-1:0] in_bit_2;
  logic [BYTE_WIDTH-1:0] in_last_bit;
  logic [1:0]            in_flag_bitstream;
  logic                  in_flag_last;
  logic                  out_ready;
  logic [BYTE_WIDTH-1:0] out_byte;
  logic                  out_valid;
  logic                  out_last;
  logic [CNT_WIDTH-1:0]  byte_count;
  logic [PTR_WIDTH:0]    fifo_level;
  logic                  overflow;
  logic                  done;

  modport master (
    output in_bit_1, in_bit_2, in_last_bit, in_flag_bitstream, in_flag_last, out_ready,
    input  out_byte, out_valid, out_last, byte_count, fifo_level, overflow, done
  );

  modport slave (
    input  in_bit_1, in_bit_2, in_last_bit, in_flag_bitstream, in_flag_last, out_ready,
    output out_byte, out_valid, out_last, byte_count, fifo_level, overflow, done
  );
endinterface

// File: rtl/bitstream_collector.sv
// Collects 0..3 encoder bytes per cycle into a circular FIFO and drains one byte per cycle,
// tagging the final byte and reporting count, overflow and completion.
module bitstream_collector #(
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PTR_WIDTH  = 4,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input logic                  top_clk,
  input logic                  top_reset,
  bitstream_collector_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StActive, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [BYTE_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] tag_q;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_WIDTH:0]    level_q, level_d, free_slots;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  overflow_q;

  logic [1:0]            n_flag, n_push;
  logic                  accepting, fits, push, drop, pop, valid, head_tag;
  logic [BYTE_WIDTH-1:0] wr_data [3];
  logic [2:0]            wr_tag;

  // Group sizing and admission; the fit check uses the level before this cycle's pop.
  always_comb begin
    n_flag = 2'd0;
    unique case (bus.in_flag_bitstream)
      2'b01:   n_flag = 2'd1;
      2'b10:   n_flag = 2'd2;
      default: n_flag = 2'd0;
    endcase
    n_push     = n_flag + {1'b0, bus.in_flag_last};
    free_slots = (PTR_WIDTH + 1)'(FIFO_DEPTH) - level_q;
    accepting  = (state_q == StIdle) || (state_q == StActive);
    fits       = (PTR_WIDTH + 1)'(n_push) <= free_slots;
    push       = accepting && (n_push != 2'd0) && fits;
    drop       = accepting && (n_push != 2'd0) && !fits;
  end

  // Slot k of the group: flagged bytes first, then the held last byte.
  always_comb begin
    wr_data[0] = (n_flag != 2'd0) ? bus.in_bit_1 : bus.in_last_bit;
    wr_data[1] = (n_flag == 2'd2) ? bus.in_bit_2 : bus.in_last_bit;
    wr_data[2] = bus.in_last_bit;
    wr_tag     = bus.in_flag_last ? (3'b001 << n_flag) : 3'b000;
  end

  always_comb begin
    valid    = (level_q != '0);
    head_tag = tag_q[rd_ptr_q];
    pop      = valid && bus.out_ready;
    level_d  = level_q;
    if (push) begin
      level_d = level_d + (PTR_WIDTH + 1)'(n_push);
    end
    if (pop) begin
      level_d = level_d - (PTR_WIDTH + 1)'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (push && bus.in_flag_last) begin
          state_d = StDrain;
        end else if (push) begin
          state_d = StActive;
        end
      end
      StActive: begin
        if (push && bus.in_flag_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && head_tag) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge top_clk) begin
    if (top_reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(n_push);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
        count_q  <= count_q + CNT_WIDTH'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only read while the level says they are live.
  always_ff @(posedge top_clk) begin
    if (push) begin
      for (int k = 0; k < 3; k++) begin
        if (k < int'(n_push)) begin
          mem_q[wr_ptr_q + PTR_WIDTH'(k)] <= wr_data[k];
          tag_q[wr_ptr_q + PTR_WIDTH'(k)] <= wr_tag[k];
        end
      end
    end
  end

  assign bus.out_valid  = valid;
  assign bus.out_byte   = valid ? mem_q[rd_ptr_q] : '0;
  assign bus.out_last   = valid && head_tag;
  assign bus.byte_count = count_q;
  assign bus.fifo_level = level_q;
  assign bus.overflow   = overflow_q;
  assign bus.done       = (state_q == StDone);

endmodule

// File: tb/tb_bitstream_collector.sv
// Directed bench for bitstream_collector: a queue scoreboard checks every popped byte,
// a small occupancy/state model checks level, count, overflow and done.
module tb_bitstream_collector;
  localparam int unsigned BW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PW    = 4;
  localparam int unsigned CW    = 32;

  logic top_clk = 1'b0;
  logic top_reset;
  always #5 top_clk = ~top_clk;

  bitstream_collector_if #(.BYTE_WIDTH(BW), .PTR_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

  bitstream_collector #(
    .BYTE_WIDTH(BW),
    .FIFO_DEPTH(DEPTH),
    .PTR_WIDTH (PW),
    .CNT_WIDTH (CW)
  ) dut (
    .top_clk  (top_clk),
    .top_reset(top_reset),
    .bus      (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  mon_e;
  int          m_level;
  int          m_count;
  logic        m_ovf;
  int          m_state;  // 0 idle, 1 active, 2 drain, 3 done
  logic [7:0]  seq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every handshake must match the oldest expected byte and its last tag.
  always @(negedge top_clk) begin
    if (top_reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_pop observed=%0h expected=none", bus.out_byte);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("pop_byte", 32'(bus.out_byte), 32'(mon_e[7:0]));
        chk("pop_last", 32'(bus.out_last), 32'(mon_e[8]));
      end
    end
  end

  task automatic step(input logic [1:0] f, input logic [7:0] b1, input logic [7:0] b2,
                      input logic l, input logic [7:0] lb, input logic rdy);
    int  nf;
    int  n;
    bit  acc;
    bit  pops;
    nf  = (f == 2'b01) ? 1 : (f == 2'b10) ? 2 : 0;
    n   = nf + int'(l);
    acc = (m_state < 2) && (n != 0) && (n <= int'(DEPTH) - m_level);
    if (m_state < 2 && n != 0 && !acc) m_ovf = 1'b1;
    if (acc) begin
      if (nf >= 1) exp_q.push_back({1'b0, b1});
      if (nf == 2) exp_q.push_back({1'b0, b2});
      if (l) exp_q.push_back({1'b1, lb});
    end
    bus.in_flag_bitstream = f;
    bus.in_bit_1          = b1;
    bus.in_bit_2          = b2;
    bus.in_flag_last      = l;
    bus.in_last_bit       = lb;
    bus.out_ready         = rdy;
    @(negedge top_clk);
    pops = (m_level != 0) && rdy;
    @(posedge top_clk);
    #1;
    if (m_state == 2 && pops && m_level == 1) m_state = 3;
    if (acc && l) m_state = 2;
    else if (m_state == 0 && acc) m_state = 1;
    m_level = m_level + (acc ? n : 0) - int'(pops);
    m_count = m_count + int'(pops);
  endtask

  task automatic idle(input logic rdy);
    step(2'b00, 8'h00, 8'h00, 1'b0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    top_reset             = 1'b1;
    bus.in_flag_bitstream = 2'b00;
    bus.in_bit_1          = '0;
    bus.in_bit_2          = '0;
    bus.in_flag_last      = 1'b0;
    bus.in_last_bit       = '0;
    bus.out_ready         = 1'b0;
    @(posedge top_clk);
    #1;
    top_reset = 1'b0;
    exp_q.delete();
    m_level = 0;
    m_count = 0;
    m_ovf   = 1'b0;
    m_state = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_level"}, 32'(bus.fifo_level), 32'(m_level));
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(m_level != 0));
    chk({tag, "_count"}, bus.byte_count, 32'(m_count));
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'(m_ovf));
    chk({tag, "_done"}, 32'(bus.done), 32'(m_state == 3));
  endtask

  initial begin
    seq = 8'h40;
    do_reset();
    // Reset state
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_byte", 32'(bus.out_byte), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk("rst_count", bus.byte_count, 32'd0);
    chk("rst_level", 32'(bus.fifo_level), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);

    // Single byte, one-cycle latency
    step(2'b01, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("t1_byte", 32'(bus.out_byte), 32'hA5);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_count0", bus.byte_count, 32'd0);
    idle(1'b1);
    chk("t1_count1", bus.byte_count, 32'd1);
    check_model("t1");

    // Two bytes plus last byte, then completion and ignored input
    step(2'b10, 8'h11, 8'h22, 1'b1, 8'h33, 1'b1);
    chk("t2_level", 32'(bus.fifo_level), 32'd3);
    repeat (3) idle(1'b1);
    chk("t2_done", 32'(bus.done), 32'd1);
    chk("t2_count", bus.byte_count, 32'd4);
    step(2'b10, 8'h55, 8'h66, 1'b1, 8'h77, 1'b1);
    check_model("t2_ignored");

    // Fill to full, drop a group, contents intact
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(2'b10, seq, seq + 8'd1, 1'b0, 8'h00, 1'b0);
      seq = seq + 8'd2;
    end
    chk("t3_full", 32'(bus.fifo_level), 32'd16);
    chk("t3_no_ovf", 32'(bus.overflow), 32'd0);
    step(2'b10, 8'hEE, 8'hEF, 1'b0, 8'h00, 1'b0);
    chk("t3_ovf", 32'(bus.overflow), 32'd1);
    check_model("t3_drop");
    repeat (16) idle(1'b1);
    check_model("t3_drained");

    // Wrap: move pointers to 14, refill to 15 across the wrap, push while popping
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(2'b10, seq, seq + 8'd1, 1'b0, 8'h00, 1'b0);
      seq = seq + 8'd2;
    end
    repeat (14) idle(1'b1);
    check_model("t4_ptr14");
    for (int i = 0; i < 7; i++) begin
      step(2'b10, seq, seq + 8'd1, 1'b0, 8'h00, 1'b0);
      seq = seq + 8'd2;
    end
    step(2'b01, seq, 8'h00, 1'b0, 8'h00, 1'b0);
    seq = seq + 8'd1;
    chk("t4_level15", 32'(bus.fifo_level), 32'd15);
    for (int i = 0; i < 4; i++) begin
      step(2'b01, seq, 8'h00, 1'b0, 8'h00, 1'b1);
      seq = seq + 8'd1;
    end
    check_model("t4_stream");
    repeat (15) idle(1'b1);
    check_model("t4_drained");

    // Full FIFO with simultaneous pop and push: push rejected
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(2'b10, seq, seq + 8'd1, 1'b0, 8'h00, 1'b0);
      seq = seq + 8'd2;
    end
    step(2'b01, 8'hC3, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("t5_level", 32'(bus.fifo_level), 32'd15);
    chk("t5_ovf", 32'(bus.overflow), 32'd1);
    repeat (15) idle(1'b1);
    check_model("t5_drained");

    // Reset mid-drain; flag 11 with last still pushes the last byte
    do_reset();
    step(2'b10, 8'h01, 8'h02, 1'b0, 8'h00, 1'b0);
    step(2'b10, 8'h03, 8'h04, 1'b0, 8'h00, 1'b0);
    step(2'b11, 8'h09, 8'h0A, 1'b1, 8'h05, 1'b0);
    check_model("t6_drain");
    chk("t6_level5", 32'(bus.fifo_level), 32'd5);
    do_reset();
    chk("t6_level0", 32'(bus.fifo_level), 32'd0);
    chk("t6_valid0", 32'(bus.out_valid), 32'd0);
    chk("t6_done0", 32'(bus.done), 32'd0);
    step(2'b01, 8'h9C, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("t6_idle_accepts", 32'(bus.out_byte), 32'h9C);
    idle(1'b1);
    check_model("t6_end");

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
